// File: rtl/core_seq.sv
`default_nettype none
// ============================================================================
//  Module      : core_seq
//  Description : Instruction sequencer for the alureg strobe interface.
//                Takes opcode/immediate bytes from a valid/ready stream,
//                decodes MOV / MVI / ALU-reg / ALU-imm / HLT and plays out
//                the ENC -> [END] -> RRD -> RRD+RWR strobe sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module core_seq #(
   parameter int MYSIZE = 8,   // data/opcode width (decode looks at [7:0])
   parameter int CNTBIT = 8    // retired-instruction counter width
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [MYSIZE-1:0] in_dat,
   input  logic              in_vld,
   output logic              in_rdy,
   output logic [MYSIZE-1:0] oDAT,
   output logic              oENC,
   output logic              oEND,
   output logic              oRRD,
   output logic              oRWR,
   output logic              busy,
   output logic              halt,
   output logic              err,
   output logic [CNTBIT-1:0] icnt
);

   // Register code 110 is the memory operand, which this sequencer rejects.
   localparam logic [2:0] REG_M  = 3'b110;
   localparam logic [7:0] OP_HLT = 8'h76;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LDC   = 3'd1,
      ST_WAITD = 3'd2,
      ST_LDD   = 3'd3,
      ST_RD    = 3'd4,
      ST_WR    = 3'd5,
      ST_HALT  = 3'd6
   } state_t;

   state_t     state;
   state_t     state_nxt;

   // Remembers whether the accepted opcode needs a trailing immediate byte.
   logic       need_imm;
   logic       need_imm_nxt;

   logic       xfer;        // byte handshake completes this cycle
   logic       dat_ld;      // capture in_dat into oDAT
   logic       err_nxt;     // illegal opcode seen this cycle
   logic       retire;      // leaving WR, instruction complete

   logic [7:0] op;
   logic [2:0] sss;
   logic [2:0] ddd;
   logic       op_hlt;
   logic       op_reg;      // MOV r,r or ALU r: no immediate
   logic       op_imm;      // MVI r or ALU imm: immediate follows

   // The decoder only ever examines the low byte of the stream.
   assign op  = in_dat[7:0];
   assign sss = op[2:0];
   assign ddd = op[5:3];

   // Ready is purely a function of the current state.
   assign in_rdy = (state == ST_IDLE) || (state == ST_WAITD);
   assign xfer   = in_vld && in_rdy;

   // Opcode classification of the byte currently on the stream.
   always_comb begin
      op_hlt = (op == OP_HLT);
      op_reg = 1'b0;
      op_imm = 1'b0;
      case (op[7:6])
         2'b01:   op_reg = (ddd != REG_M) && (sss != REG_M);   // MOV
         2'b00:   op_imm = (sss == REG_M) && (ddd != REG_M);   // MVI
         2'b10:   op_reg = (sss != REG_M);                     // ALU reg
         default: op_imm = (sss == REG_M);                     // ALU imm
      endcase
   end

   // State register plus the captured "immediate needed" flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         need_imm <= 1'b0;
      end else begin
         state    <= state_nxt;
         need_imm <= need_imm_nxt;
      end
   end

   // Next-state decode and per-cycle control events.
   always_comb begin
      state_nxt    = state;
      need_imm_nxt = need_imm;
      dat_ld       = 1'b0;
      err_nxt      = 1'b0;
      retire       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (xfer) begin
               if (op_hlt) begin
                  // HLT issues no strobes and never leaves HALT.
                  state_nxt = ST_HALT;
               end else if (op_reg || op_imm) begin
                  state_nxt    = ST_LDC;
                  dat_ld       = 1'b1;
                  need_imm_nxt = op_imm;
               end else begin
                  // Illegal byte: flag it and keep accepting.
                  err_nxt = 1'b1;
               end
            end
         end
         ST_LDC: begin
            state_nxt = need_imm ? ST_WAITD : ST_RD;
         end
         ST_WAITD: begin
            if (xfer) begin
               state_nxt = ST_LDD;
               dat_ld    = 1'b1;
            end
         end
         ST_LDD: begin
            state_nxt = ST_RD;
         end
         ST_RD: begin
            state_nxt = ST_WR;
         end
         ST_WR: begin
            state_nxt = ST_IDLE;
            retire    = 1'b1;
         end
         ST_HALT: begin
            state_nxt = ST_HALT;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Registered Moore outputs, decoded from the state being entered so they
   // line up with the state register without any combinational glitching.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oENC <= 1'b0;
         oEND <= 1'b0;
         oRRD <= 1'b0;
         oRWR <= 1'b0;
         busy <= 1'b0;
         halt <= 1'b0;
         err  <= 1'b0;
      end else begin
         oENC <= (state_nxt == ST_LDC);
         oEND <= (state_nxt == ST_LDD);
         oRRD <= (state_nxt == ST_RD) || (state_nxt == ST_WR);
         oRWR <= (state_nxt == ST_WR);
         busy <= (state_nxt == ST_LDC) || (state_nxt == ST_WAITD) ||
                 (state_nxt == ST_LDD) || (state_nxt == ST_RD)    ||
                 (state_nxt == ST_WR);
         halt <= (state_nxt == ST_HALT);
         err  <= err_nxt;
      end
   end

   // Data byte to alureg: opcode at accept, replaced by the immediate in LDD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oDAT <= '0;
      end else if (dat_ld) begin
         oDAT <= in_dat;
      end
   end

   // Retired-instruction counter, bumped as WR completes; wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         icnt <= '0;
      end else if (retire) begin
         icnt <= icnt + CNTBIT'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_core_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_seq
//  Description : Self-checking bench for core_seq. Drivers check cycle-exact
//                strobe timing; a scoreboard of expected retirements / error
//                pulses is popped by a monitor when the DUT produces them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_core_seq;

   localparam int MYSIZE = 8;
   localparam int CNTBIT = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [MYSIZE-1:0] in_dat = '0;
   logic              in_vld = 1'b0;
   logic              in_rdy;
   logic [MYSIZE-1:0] oDAT;
   logic              oENC, oEND, oRRD, oRWR;
   logic              busy, halt, err;
   logic [CNTBIT-1:0] icnt;

   always #5 clk = ~clk;

   core_seq #(.MYSIZE(MYSIZE), .CNTBIT(CNTBIT)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_dat (in_dat),
      .in_vld (in_vld),
      .in_rdy (in_rdy),
      .oDAT   (oDAT),
      .oENC   (oENC),
      .oEND   (oEND),
      .oRRD   (oRRD),
      .oRWR   (oRWR),
      .busy   (busy),
      .halt   (halt),
      .err    (err),
      .icnt   (icnt)
   );

   typedef struct {
      bit         is_err;
      logic [7:0] dat;
      logic [7:0] cnt;
   } exp_t;

   exp_t       sb[$];
   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_cnt  = 8'd0;
   bit         cnt_pending = 1'b0;
   logic [7:0] cnt_expect  = 8'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic expect_st(input string tag, input logic [3:0] s, input logic rdy, input logic bsy);
      check({tag, "_strb"}, {oENC, oEND, oRRD, oRWR}, s);
      check({tag, "_rdy"},  in_rdy, rdy);
      check({tag, "_busy"}, busy, bsy);
   endtask

   // Monitor: pop the scoreboard whenever the DUT retires or flags an error.
   always @(negedge clk) begin
      if (!rst_n) begin
         cnt_pending = 1'b0;
      end else begin
         if (cnt_pending) begin
            check("icnt_after_wr", icnt, cnt_expect);
            cnt_pending = 1'b0;
         end
         if (oRWR === 1'b1) begin
            if (sb.size() == 0) begin
               check("wr_without_instr", oRWR, 1'b0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("wr_order", e.is_err, 1'b0);
               check("wr_odat", oDAT, e.dat);
               cnt_expect  = e.cnt;
               cnt_pending = 1'b1;
            end
         end
         if (err === 1'b1) begin
            if (sb.size() == 0) begin
               check("err_without_instr", err, 1'b0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("err_order", e.is_err, 1'b1);
            end
         end
      end
   end

   // Register-register op: ENC@1, RRD@2, RRD+RWR@3, ready again @4.
   task automatic run_reg(input logic [7:0] op);
      check("reg_c0_rdy", in_rdy, 1'b1);
      in_dat = op;
      in_vld = 1'b1;
      exp_cnt++;
      sb.push_back('{is_err: 1'b0, dat: op, cnt: exp_cnt});
      cyc();
      in_dat = 8'h55;                       // junk while not ready
      expect_st("reg_c1", 4'b1000, 1'b0, 1'b1);
      check("reg_c1_dat", oDAT, op);
      cyc();
      expect_st("reg_c2", 4'b0010, 1'b0, 1'b1);
      in_vld = 1'b0;
      cyc();
      expect_st("reg_c3", 4'b0011, 1'b0, 1'b1);
      cyc();
      expect_st("reg_c4", 4'b0000, 1'b1, 1'b0);
   endtask

   // Immediate op with `gap` idle cycles in WAITD before the data byte.
   task automatic run_imm(input logic [7:0] op, input logic [7:0] imm, input int gap);
      check("imm_c0_rdy", in_rdy, 1'b1);
      in_dat = op;
      in_vld = 1'b1;
      exp_cnt++;
      sb.push_back('{is_err: 1'b0, dat: imm, cnt: exp_cnt});
      cyc();
      in_dat = 8'hC3;                       // junk offered during LDC
      expect_st("imm_ldc", 4'b1000, 1'b0, 1'b1);
      check("imm_ldc_dat", oDAT, op);
      cyc();
      for (int i = 0; i < gap; i++) begin
         expect_st("imm_wait", 4'b0000, 1'b1, 1'b1);
         check("imm_wait_dat", oDAT, op);
         in_vld = 1'b0;
         cyc();
      end
      expect_st("imm_wait_last", 4'b0000, 1'b1, 1'b1);
      in_dat = imm;
      in_vld = 1'b1;
      cyc();
      in_dat = 8'h3C;                       // junk offered during LDD
      expect_st("imm_ldd", 4'b0100, 1'b0, 1'b1);
      check("imm_ldd_dat", oDAT, imm);
      cyc();
      in_vld = 1'b0;
      expect_st("imm_rd", 4'b0010, 1'b0, 1'b1);
      cyc();
      expect_st("imm_wr", 4'b0011, 1'b0, 1'b1);
      check("imm_wr_dat", oDAT, imm);
      cyc();
      expect_st("imm_done", 4'b0000, 1'b1, 1'b0);
   endtask

   // Illegal opcode: one-cycle err, no strobes, count unchanged.
   task automatic run_illegal(input logic [7:0] op);
      in_dat = op;
      in_vld = 1'b1;
      sb.push_back('{is_err: 1'b1, dat: 8'h00, cnt: exp_cnt});
      cyc();
      in_vld = 1'b0;
      expect_st("ill_c1", 4'b0000, 1'b1, 1'b0);
      check("ill_err_hi", err, 1'b1);
      check("ill_icnt", icnt, exp_cnt);
      cyc();
      expect_st("ill_c2", 4'b0000, 1'b1, 1'b0);
      check("ill_err_lo", err, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      expect_st(tag, 4'b0000, 1'b1, 1'b0);
      check({tag, "_odat"}, oDAT, 8'h00);
      check({tag, "_halt"}, halt, 1'b0);
      check({tag, "_err"},  err,  1'b0);
      check({tag, "_icnt"}, icnt, 8'h00);
   endtask

   // Asserts reset asynchronously between edges, checks, then releases.
   task automatic pulse_reset(input string tag);
      rst_n  = 1'b0;
      in_vld = 1'b0;
      #1;
      check_reset_outputs(tag);
      sb.delete();
      exp_cnt = 8'd0;
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   function automatic logic [7:0] rand_reg_op();
      logic [2:0] s;
      logic [2:0] d;
      s = 3'($urandom_range(0, 6));
      d = 3'($urandom_range(0, 6));
      if (s == 3'd6) s = 3'd7;
      if (d == 3'd6) d = 3'd7;
      if ($urandom_range(0, 1) == 0) return {2'b01, d, s};
      return {2'b10, 3'($urandom_range(0, 7)), s};
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      cyc();
      cyc();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      cyc();

      run_imm(8'h3E, 8'hAA, 0);    // MVI A,AAh
      check("icnt_mvi", icnt, 8'd1);
      run_reg(8'hAF);              // XRA A
      check("icnt_xra", icnt, 8'd2);
      run_reg(8'h47);              // MOV B,A
      run_imm(8'h06, 8'h12, 5);    // MVI B with a long data gap
      run_imm(8'hFE, 8'h34, 2);    // CPI imm

      run_illegal(8'h46);          // MOV B,M
      run_illegal(8'h36);          // MVI M
      run_illegal(8'h01);
      run_illegal(8'hC7);
      check("icnt_after_illegal", icnt, 8'd5);

      // Enough register ops to wrap the counter through zero.
      for (int i = 0; i < 256; i++) begin
         run_reg(rand_reg_op());
      end
      check("icnt_wrapped", icnt, 8'd5);

      // HLT: sticky halt, stream ignored even with valid held high.
      in_dat = 8'h76;
      in_vld = 1'b1;
      cyc();
      in_dat = 8'h3E;
      for (int i = 0; i < 4; i++) begin
         expect_st("halt", 4'b0000, 1'b0, 1'b0);
         check("halt_flag", halt, 1'b1);
         check("halt_icnt", icnt, 8'd5);
         cyc();
      end
      check("sb_empty_halt", sb.size(), 0);
      pulse_reset("reset_halt");

      // Reset in the middle of RD: the write must never appear.
      in_dat = 8'h47;
      in_vld = 1'b1;
      exp_cnt++;
      sb.push_back('{is_err: 1'b0, dat: 8'h47, cnt: exp_cnt});
      cyc();
      in_vld = 1'b0;
      expect_st("abort_ldc", 4'b1000, 1'b0, 1'b1);
      cyc();
      expect_st("abort_rd", 4'b0010, 1'b0, 1'b1);
      pulse_reset("reset_mid_rd");
      for (int i = 0; i < 3; i++) begin
         expect_st("post_abort", 4'b0000, 1'b1, 1'b0);
         cyc();
      end
      run_reg(8'h78);              // MOV A,B after recovery
      check("icnt_recover", icnt, 8'd1);

      check("sb_empty_end", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
